// File: rtl/seq_divider_16x8_if.sv
// Start/busy/done handshake and result bus of the 16/8 sequential divider.
interface seq_divider_16x8_if;
  localparam int unsigned DVD_W = 16;
  localparam int unsigned DVS_W = 8;

  logic             start;
  logic [DVD_W-1:0] dividend;
  logic [DVS_W-1:0] divisor;
  logic             busy;
  logic             done;
  logic [DVD_W-1:0] quotient;
  logic [DVS_W-1:0] remainder;
  logic             q_ovf;
  logic             div_by_zero;

  // Requester side: issues operands, observes results.
  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, q_ovf, div_by_zero
  );

  // Divider side.
  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, q_ovf, div_by_zero
  );
endinterface

// File: rtl/seq_divider_16x8.sv
// Radix-2 restoring divider, 16-bit dividend by 8-bit divisor, one quotient bit per clock.
module seq_divider_16x8 (
  input  logic                clk,
  input  logic                rst_n,
  seq_divider_16x8_if.slave   bus
);
  localparam int unsigned DVD_W  = 16;
  localparam int unsigned DVS_W  = 8;
  localparam int unsigned PREM_W = DVS_W + 1;
  localparam int unsigned CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state;
  logic [DVD_W-1:0]  dq;     // dividend shifting out the top, quotient shifting in at the bottom
  logic [DVS_W-1:0]  dvs;
  logic [PREM_W-1:0] prem;
  logic [CNT_W-1:0]  cnt;

  logic [PREM_W-1:0] trial_c;
  logic [PREM_W-1:0] prem_next_c;
  logic              qbit_c;
  logic [DVD_W-1:0]  dq_next_c;

  // One restoring step; prem[8] is always 0 here, so dropping it on the shift loses nothing.
  always_comb begin
    trial_c     = PREM_W'({prem, dq[DVD_W-1]});
    qbit_c      = (trial_c >= PREM_W'(dvs));
    prem_next_c = trial_c;
    if (qbit_c) begin
      prem_next_c = trial_c - PREM_W'(dvs);
    end
    dq_next_c   = {dq[DVD_W-2:0], qbit_c};
  end

  // Control FSM, working registers and registered result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      dq              <= '0;
      dvs             <= '0;
      prem            <= '0;
      cnt             <= '0;
      bus.busy        <= 1'b0;
      bus.done        <= 1'b0;
      bus.quotient    <= '0;
      bus.remainder   <= '0;
      bus.q_ovf       <= 1'b0;
      bus.div_by_zero <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            dq       <= bus.dividend;
            dvs      <= bus.divisor;
            prem     <= '0;
            cnt      <= '0;
            bus.busy <= 1'b1;
            if (bus.divisor == '0) begin
              // Divide by zero resolves immediately with saturated quotient.
              bus.quotient    <= '1;
              bus.remainder   <= '0;
              bus.q_ovf       <= 1'b1;
              bus.div_by_zero <= 1'b1;
              bus.done        <= 1'b1;
              state           <= DONE;
            end else begin
              state <= CALC;
            end
          end
        end
        CALC: begin
          prem <= prem_next_c;
          dq   <= dq_next_c;
          cnt  <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(15)) begin
            bus.quotient    <= dq_next_c;
            bus.remainder   <= prem_next_c[DVS_W-1:0];
            bus.q_ovf       <= |dq_next_c[DVD_W-1:DVS_W];
            bus.div_by_zero <= 1'b0;
            bus.done        <= 1'b1;
            state           <= DONE;
          end
        end
        DONE: begin
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_seq_divider_16x8.sv
// Self-checking bench for seq_divider_16x8: vector table, corner sequences, random back-to-back.
module tb_seq_divider_16x8;
  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  seq_divider_16x8_if bus ();

  seq_divider_16x8 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [15:0] dvd;
    logic [7:0]  dvs;
    logic [15:0] q;
    logic [7:0]  r;
    logic        ovf;
    logic        dbz;
    int          lat;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: plain integer division with the divide-by-zero convention.
  function automatic void model(input logic [15:0] a, input logic [7:0] b,
                                output logic [15:0] q, output logic [7:0] r,
                                output logic ovf, output logic dbz);
    if (b == 8'd0) begin
      q = 16'hFFFF; r = 8'h00; ovf = 1'b1; dbz = 1'b1;
    end else begin
      q   = a / 16'(b);
      r   = 8'(a % 16'(b));
      ovf = (q > 16'd255);
      dbz = 1'b0;
    end
  endfunction

  // Issue one request with a single-cycle start pulse; lat = cycles from acceptance edge to done.
  task automatic run_op(input logic [15:0] a, input logic [7:0] b, output int lat);
    @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    @(negedge clk);
    bus.start = 1'b0;
    lat = 0;
    while (!bus.done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    if (!bus.done) chk("done_timeout", 32'(0), 32'(1));
  endtask

  task automatic chk_idle_after(input string name);
    @(negedge clk);
    chk({name, "_busy_low"}, 32'(bus.busy), 32'(0));
    chk({name, "_done_low"}, 32'(bus.done), 32'(0));
  endtask

  initial begin
    int lat;
    logic [15:0] mq;
    logic [7:0]  mr;
    logic        movf, mdbz;

    vecs[0] = '{16'h3039, 8'h7B, 16'h0064, 8'h2D, 1'b0, 1'b0, 16};
    vecs[1] = '{16'hFFFF, 8'hFF, 16'h0101, 8'h00, 1'b1, 1'b0, 16};
    vecs[2] = '{16'hFFFF, 8'h01, 16'hFFFF, 8'h00, 1'b1, 1'b0, 16};
    vecs[3] = '{16'h1234, 8'h00, 16'hFFFF, 8'h00, 1'b1, 1'b1, 0};
    vecs[4] = '{16'h00FF, 8'h01, 16'h00FF, 8'h00, 1'b0, 1'b0, 16};
    vecs[5] = '{16'h0000, 8'h05, 16'h0000, 8'h00, 1'b0, 1'b0, 16};
    vecs[6] = '{16'h00FE, 8'hFF, 16'h0000, 8'hFE, 1'b0, 1'b0, 16};

    // Reset state
    rst_n        = 1'b0;
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 32'(0));
    chk("rst_done", 32'(bus.done), 32'(0));
    chk("rst_q",    32'(bus.quotient), 32'(0));
    chk("rst_r",    32'(bus.remainder), 32'(0));
    chk("rst_ovf",  32'(bus.q_ovf), 32'(0));
    chk("rst_dbz",  32'(bus.div_by_zero), 32'(0));
    rst_n = 1'b1;

    // Directed vector table
    for (int i = 0; i < 7; i++) begin
      run_op(vecs[i].dvd, vecs[i].dvs, lat);
      chk("vec_q",   32'(bus.quotient),    32'(vecs[i].q));
      chk("vec_r",   32'(bus.remainder),   32'(vecs[i].r));
      chk("vec_ovf", 32'(bus.q_ovf),       32'(vecs[i].ovf));
      chk("vec_dbz", 32'(bus.div_by_zero), 32'(vecs[i].dbz));
      chk("vec_lat", 32'(lat),             32'(vecs[i].lat));
      chk("vec_busy_at_done", 32'(bus.busy), 32'(1));
      chk_idle_after("vec");
    end

    // Start while busy is ignored; outputs hold during CALC
    run_op(16'h00FF, 8'h01, lat);
    chk("hold_pre_q", 32'(bus.quotient), 32'(16'h00FF));
    @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = 16'h3039;
    bus.divisor  = 8'h7B;
    @(negedge clk);
    for (int n = 0; n <= 16; n++) begin
      if (n < 16) begin
        if (bus.quotient !== 16'h00FF || bus.remainder !== 8'h00 || bus.done !== 1'b0 || bus.busy !== 1'b1)
          chk("hold_during_calc", {16'(bus.quotient), 8'(bus.remainder), 6'd0, bus.done, bus.busy},
              {16'h00FF, 8'h00, 6'd0, 1'b0, 1'b1});
        else
          tests++;
      end else begin
        chk("ign_done", 32'(bus.done),      32'(1));
        chk("ign_q",    32'(bus.quotient),  32'(16'h0064));
        chk("ign_r",    32'(bus.remainder), 32'(8'h2D));
      end
      bus.start = (n == 4 || n == 16);
      if (bus.start) begin
        bus.dividend = 16'h0001;
        bus.divisor  = 8'h01;
      end
      @(negedge clk);
    end
    chk("ign_busy_after", 32'(bus.busy), 32'(0));
    chk("ign_done_after", 32'(bus.done), 32'(0));
    bus.start = 1'b0;
    begin
      int extra = 0;
      repeat (20) begin
        @(negedge clk);
        if (bus.done || bus.busy) extra++;
      end
      chk("ign_no_second_op", 32'(extra), 32'(0));
      chk("ign_q_held", 32'(bus.quotient), 32'(16'h0064));
    end

    // Asynchronous reset mid-CALC
    @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = 16'hFFFF;
    bus.divisor  = 8'h01;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (8) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(bus.busy), 32'(0));
    chk("arst_done", 32'(bus.done), 32'(0));
    chk("arst_q",    32'(bus.quotient), 32'(0));
    chk("arst_r",    32'(bus.remainder), 32'(0));
    chk("arst_ovf",  32'(bus.q_ovf), 32'(0));
    chk("arst_dbz",  32'(bus.div_by_zero), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    begin
      int spurious = 0;
      repeat (40) begin
        @(negedge clk);
        if (bus.done) spurious++;
      end
      chk("arst_no_done", 32'(spurious), 32'(0));
    end
    run_op(16'h3039, 8'h7B, lat);
    chk("arst_fresh_q",   32'(bus.quotient),  32'(16'h0064));
    chk("arst_fresh_r",   32'(bus.remainder), 32'(8'h2D));
    chk("arst_fresh_lat", 32'(lat),           32'(16));
    chk_idle_after("arst_fresh");

    // Random full-range operands against the arithmetic model
    for (int i = 0; i < 200; i++) begin
      logic [15:0] a;
      logic [7:0]  b;
      a = 16'($urandom);
      b = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
      model(a, b, mq, mr, movf, mdbz);
      run_op(a, b, lat);
      chk("rnd_q",   32'(bus.quotient),    32'(mq));
      chk("rnd_r",   32'(bus.remainder),   32'(mr));
      chk("rnd_ovf", 32'(bus.q_ovf),       32'(movf));
      chk("rnd_dbz", 32'(bus.div_by_zero), 32'(mdbz));
      chk("rnd_lat", 32'(lat),             32'(mdbz ? 0 : 16));
      chk_idle_after("rnd");
    end

    // Back-to-back recovery of products with start held high
    begin
      logic [15:0] exp_q[$];
      logic [7:0]  exp_r[$];
      int          acc_cyc[$];
      int          n_ops  = 2500;
      int          issued = 0;
      int          seen   = 0;
      int          cyc    = 0;
      while (seen < n_ops && cyc < n_ops * 20 + 100) begin
        @(negedge clk);
        cyc++;
        if (bus.done) begin
          if (exp_q.size() == 0) begin
            chk("b2b_spurious_done", 32'(1), 32'(0));
          end else begin
            chk("b2b_q",   32'(bus.quotient),  32'(exp_q.pop_front()));
            chk("b2b_r",   32'(bus.remainder), 32'(exp_r.pop_front()));
            chk("b2b_ovf", 32'(bus.q_ovf),     32'(0));
            chk("b2b_dbz", 32'(bus.div_by_zero), 32'(0));
            chk("b2b_lat", 32'(cyc - acc_cyc.pop_front()), 32'(17));
          end
          seen++;
        end
        if (!bus.busy) begin
          if (issued < n_ops) begin
            int a, b, r;
            a = int'($urandom_range(0, 255));
            b = int'($urandom_range(1, 255));
            r = int'($urandom_range(0, b - 1));
            bus.start    = 1'b1;
            bus.dividend = 16'(a * b + r);
            bus.divisor  = 8'(b);
            exp_q.push_back(16'(a));
            exp_r.push_back(8'(r));
            acc_cyc.push_back(cyc);
            issued++;
          end else begin
            bus.start = 1'b0;
          end
        end
      end
      bus.start = 1'b0;
      chk("b2b_done_count", 32'(seen), 32'(n_ops));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
